// File: rtl/adder_pkg.sv
// adder_pkg: shared encodings, flag bundle and configuration check for the pipelined adder
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } adder_flags_t;

    function automatic bit cfg_ok(input int width, input int stages, input int block);
        return stages >= 1 && stages <= 8 && block >= 1 && width % (stages * block) == 0;
    endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// cla_group: BLOCK-bit lookahead group producing sum and group propagate/generate
module cla_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             cin_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             p_o,
    output logic             g_o
);

    // group P/G depend only on the operands so the slice carry logic never waits on cin
    always_comb begin
        g_o = 1'b0;
        for (int i = 0; i < BLOCK; i++) g_o = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & g_o);
        p_o = &(a_i ^ b_i);
    end

    // bit carries within the group from the group carry-in
    always_comb begin
        logic c;
        c = cin_i;
        sum_o = '0;
        for (int i = 0; i < BLOCK; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & c);
        end
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: elastic STAGES-deep CLA add/sub; ADDER_FLAGS_EN enables ovf/zero/neg
module pipelined_cla_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SW  = WIDTH / STAGES;
    localparam int NG  = WIDTH / BLOCK;
    localparam int GPS = SW / BLOCK;

    if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_cfg_check
        $error("WIDTH must be a multiple of STAGES*BLOCK and STAGES must be 1..8");
    end

    logic [STAGES-1:0] valid_q, c_q, rdy, vin, cin, cout_s;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  ain [STAGES];
    logic [WIDTH-1:0]  bin [STAGES];
    logic [NG-1:0]     gp, gg, gc;
    logic [WIDTH-1:0]  gsum;
    logic              unused_ops;
    adder_flags_t      flags;

    // stage 0 works on the ports, later stages on the operands carried by the previous stage
    always_comb begin
        cin = '0;
        vin = '0;
        ain[0] = a;
        bin[0] = (op_sub == OP_SUB) ? ~b : b;
        cin[0] = op_sub == OP_SUB;
        vin[0] = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            ain[s] = a_q[s-1];
            bin[s] = b_q[s-1];
            cin[s] = c_q[s-1];
            vin[s] = valid_q[s-1];
        end
    end

    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a_i  (ain[j / GPS][j*BLOCK +: BLOCK]),
            .b_i  (bin[j / GPS][j*BLOCK +: BLOCK]),
            .cin_i(gc[j]),
            .sum_o(gsum[j*BLOCK +: BLOCK]),
            .p_o  (gp[j]),
            .g_o  (gg[j])
        );
    end

    // group carries across each slice, seeded by that slice's carry-in
    always_comb begin
        logic c;
        c = 1'b0;
        gc = '0;
        cout_s = '0;
        for (int j = 0; j < NG; j++) begin
            if (j % GPS == 0) c = cin[j / GPS];
            gc[j] = c;
            c = gg[j] | (gp[j] & c);
            if (j % GPS == GPS - 1) cout_s[j / GPS] = c;
        end
    end

    // each stage drops its freshly computed slice into the partial sum passed down
    always_comb begin
        sum_d[0] = '0;
        for (int s = 1; s < STAGES; s++) sum_d[s] = sum_q[s-1];
        for (int s = 0; s < STAGES; s++) sum_d[s][s*SW +: SW] = gsum[s*SW +: SW];
    end

    // a stage may load when empty or when its content leaves this cycle
    always_comb begin
        logic r;
        r = out_ready;
        rdy = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            r = !valid_q[s] || r;
            rdy[s] = r;
        end
    end

    // operand bits outside a stage's slice are only forwarded, the last stage's copies are dead
    always_comb begin
        unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};
        for (int s = 0; s < STAGES; s++) unused_ops = unused_ops ^ (^{ain[s], bin[s]});
    end

    // stage registers; data is captured only together with a valid operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            c_q     <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (rdy[s]) valid_q[s] <= vin[s];
                if (rdy[s] && vin[s]) begin
                    a_q[s]   <= ain[s];
                    b_q[s]   <= bin[s];
                    c_q[s]   <= cout_s[s];
                    sum_q[s] <= sum_d[s];
                end
            end
        end
    end

`ifdef ADDER_FLAGS_EN
    logic ovf_q, zero_q, neg_q, cmsb;

    assign cmsb = ain[STAGES-1][WIDTH-1] ^ bin[STAGES-1][WIDTH-1] ^ gsum[WIDTH-1];

    // flags come from the complete sum formed in the final stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (rdy[STAGES-1] && vin[STAGES-1]) begin
            ovf_q  <= cmsb ^ cout_s[STAGES-1];
            zero_q <= sum_d[STAGES-1] == '0;
            neg_q  <= sum_d[STAGES-1][WIDTH-1];
        end
    end

    assign flags = '{cout: c_q[STAGES-1], ovf: ovf_q, zero: zero_q, neg: neg_q};
`else
    assign flags = '{cout: c_q[STAGES-1], ovf: 1'b0, zero: 1'b0, neg: 1'b0};
`endif

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign {cout, ovf, zero, neg} = flags;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: randomized scoreboard bench for the pipelined add/sub
module tb_pipelined_cla_addsub
    import adder_pkg::*;
#(
    parameter int W = 32,
    parameter int S = 2,
    parameter int B = 4
);

    logic         clk, rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic         cout, ovf, zero, neg;
    logic [W-1:0] a, b, sum;

    typedef struct {
        logic [W-1:0] s;
        logic [3:0]   f;
        int           acc;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           tests = 0, fails = 0, cyc = 0, last_low = -1;
    bit           rnd = 0, hold_v = 0;
    logic [W-1:0] hold_sum;
    logic [3:0]   hold_f;

    pipelined_cla_addsub #(.WIDTH(W), .BLOCK(B), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // reference: plain integer arithmetic and two's-complement sign rules
    function automatic exp_t model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
        exp_t         r;
        logic [W:0]   full;
        logic         c, v;
        if (op == OP_SUB) begin
            full = {1'b0, x} - {1'b0, y};
            c = x >= y;
            v = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y};
            c = full[W];
            v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        end
        r.s = full[W-1:0];
`ifdef ADDER_FLAGS_EN
        r.f = {c, v, r.s == '0, r.s[W-1]};
`else
        r.f = {c, 3'b000};
`endif
        r.acc = acc;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r = '0;
        for (int i = 0; i < (W + 31) / 32; i++) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    function automatic logic [W-1:0] pick_w();
        int p = $urandom_range(0, 7);
        return p == 0 ? '1 : p == 1 ? '0 : p == 2 ? {1'b0, {(W-1){1'b1}}} : rnd_w();
    endfunction

    // output monitor and input-side scoreboard push
    always @(negedge clk) begin
        if (!rst_n) hold_v = 0;
        else begin
            if (hold_v) begin
                chk("hold_valid", W'(out_valid), W'(1));
                chk("hold_sum", sum, hold_sum);
                chk("hold_flags", W'({cout, ovf, zero, neg}), W'(hold_f));
            end
            hold_v   = out_valid && !out_ready;
            hold_sum = sum;
            hold_f   = {cout, ovf, zero, neg};
            if (!out_ready) last_low = cyc;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_output", W'(out_valid), W'(0));
                else begin
                    e = q.pop_front();
                    chk("sum", sum, e.s);
                    chk("flags", W'({cout, ovf, zero, neg}), W'(e.f));
                    if (last_low < e.acc) chk("latency", W'(cyc - e.acc), W'(S));
                    else chk("latency_min", W'(cyc >= e.acc + S), W'(1));
                end
            end
            if (in_valid && in_ready) q.push_back(model(op_sub, a, b, cyc));
        end
    end

    task automatic send(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        in_valid = 1;
        op_sub = op;
        a = x;
        b = y;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (n == 100) chk("accept_timeout", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", W'(q.size()), W'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_sum", sum, '0);
        chk("rst_flags", W'({cout, ovf, zero, neg}), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        int cnt;
        bit acc;
        rst_n = 1;
        in_valid = 0;
        op_sub = 0;
        a = '0;
        b = '0;
        out_ready = 1;
        #2 rst_n = 0;
        #1 chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        send(OP_ADD, '1, W'(1));
        send(OP_ADD, {1'b0, {(W-1){1'b1}}}, W'(1));
        send(OP_SUB, W'(5), W'(7));
        drain();

        for (int i = 1; i <= 4; i++) send(OP_ADD, W'(i), W'(i));
        drain();

        out_ready = 0;
        cnt = 0;
        in_valid = 1;
        op_sub = 1'($urandom_range(0, 1));
        a = pick_w();
        b = pick_w();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                cnt++;
                op_sub = 1'($urandom_range(0, 1));
                a = pick_w();
                b = pick_w();
            end
        end
        in_valid = 0;
        chk("full_accepts", W'(cnt), W'(S));
        chk("full_in_ready", W'(in_ready), W'(0));
        drain();

        send(OP_ADD, W'(9), W'(10));
        send(OP_SUB, W'(3), W'(1));
        #1 rst_n = 0;
        #1 chk_reset_outputs();
        q.delete();
        @(posedge clk);
        #1 rst_n = 1;
        repeat (8) @(posedge clk);
        #1 chk("post_reset_idle", W'(out_valid), W'(0));
        send(OP_ADD, W'(3), W'(4));
        drain();

        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(1'($urandom_range(0, 1)), pick_w(), pick_w());
        end
        rnd = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the RISC datapath ALU; it replaces the fixed 32-bit combinational adder. The carry chain is split across STAGES register stages with a valid/ready handshake on both sides, so the ALU can issue one operation per cycle and absorb back-pressure from writeback. Result flags are produced alongside the sum.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of STAGES*BLOCK.
- BLOCK, 4: bits per lookahead group (cla_group instance).
- STAGES, 2: pipeline register stages, 1..8; also the latency.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- op_sub  input  1  0 = a+b, 1 = a−b.
- a  input  WIDTH  left operand.
- b  input  WIDTH  right operand.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer takes result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Subtract: b inverted, carry-in = 1. Add: carry-in = 0.
- Word split into STAGES slices of WIDTH/STAGES bits. Stage k computes slice k with BLOCK-bit lookahead groups and group P/G over the slice, using the carry registered by stage k−1; lower result slices and upper operand slices travel in stage registers (staggered).
- ovf = carry into MSB XOR carry out of MSB; zero/neg derived from the complete sum in the final stage.
- Elastic pipeline: stage k loads when empty or when its content moves to stage k+1 (or out) in the same cycle. in_ready = !valid[0] || stage 0 advances; combinational from out_ready through the chain; no combinational path from in_valid to in_ready.
- While out_valid && !out_ready: sum and all flags held stable; no operation lost or duplicated.
- No internal state beyond stage registers; no FSM beyond per-stage valid bits.

## Timing
- Reset (async assert, sync-released by system): all valid bits 0, all data registers 0; outputs out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0; in_ready=1 one gate after reset.
- Latency: operand accepted at edge N → out_valid at edge N+STAGES with out_ready held 1.
- Throughput: one op per cycle with out_ready=1.
- Full pipeline + out_ready=0: in_ready=0 that cycle; accept resumes in the cycle out_ready returns 1 (simultaneous drain and accept allowed).
- Reset mid-operation: all in-flight ops discarded; no output after reset release until a new accept.
- Critical path per stage: one slice of group lookahead, ≤ WIDTH/STAGES bits.

## Configuration
- ADDER_FLAGS_EN defined: ovf, zero, neg computed and registered as above.
- Not defined: flag logic and registers omitted; ovf, zero, neg ports remain and drive constant 0; cout unaffected.

## Structure
- Package adder_pkg: op encoding constants OP_ADD=1'b0, OP_SUB=1'b1; packed struct adder_flags_t {cout, ovf, zero, neg}; elaboration-time check function for WIDTH % (STAGES*BLOCK) == 0.
- Sub-module cla_group: BLOCK-bit lookahead (a, b, cin → sum, group P, group G), instantiated WIDTH/BLOCK times via generate.

## Test plan
- WIDTH=32, STAGES=2, add 0xFFFFFFFF+0x00000001 → sum 0x00000000, cout=1, zero=1, ovf=0, out_valid 2 cycles after accept.
- Add 0x7FFFFFFF+0x00000001 → sum 0x80000000, ovf=1, neg=1, cout=0; subtract 5−7 → 0xFFFFFFFE, cout=0, neg=1, ovf=0.
- Four back-to-back accepts (1+1, 2+2, 3+3, 4+4), out_ready=1 → results 2,4,6,8 on four consecutive cycles starting 2 cycles after first accept.
- Hold out_ready=0 with continuous in_valid → exactly 2 accepts then in_ready=0; sum stays stable; release → results in order, none dropped or duplicated.
- Assert rst_n=0 with 2 ops in flight → out_valid=0 and all outputs 0 immediately; after release no result emerges until a new accept.
- Build without ADDER_FLAGS_EN, 0x7FFFFFFF+1 → sum 0x80000000, ovf=zero=neg=0; repeat with WIDTH=64, STAGES=4, BLOCK=4: 0xFFFFFFFFFFFFFFFF+1 → sum 0, cout=1, latency 4.
